// File: rtl/wb_sys_pkg.sv
// Shared Wishbone system types: bridge FSM states and CTI burst encodings.
// Used by the timeout bridge and its stall counter.
package wb_sys_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    TMO   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int STALL_W = 16;

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 bus bundle with master and slave views.
// Widths set per instance; SEL is one bit per data byte.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic [DATA_WIDTH/8-1:0] sel;
  logic                    we;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    cyc;
  logic                    stb;
  logic                    ack;
  logic                    err;

  modport master (
    output adr, dat_w, sel, we, cti, bte, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cti, bte, cyc, stb,
    output dat_r, ack, err
  );

endinterface

// File: rtl/wb_stall_counter.sv
// Counts consecutive stalled beats; flags the last stall before timeout.
// Any non-stall cycle restarts the count from zero.
module wb_stall_counter
  import wb_sys_pkg::*;
#(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rstn,
  input  logic inc,
  output logic hit
);

  localparam logic [STALL_W-1:0] LAST = STALL_W'(LIMIT - 1);

  logic [STALL_W-1:0] cnt;

  assign hit = inc && (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/wb_timeout_bridge.sv
// Wishbone pass-through that forces ERR on a slave stalling too long.
// Define WB_TIMEOUT_BRIDGE_CAPTURE_EN to add the failing-address capture.
module wb_timeout_bridge
  import wb_sys_pkg::*;
#(
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int WB_DATA_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rstn,
  wb_if.slave         m,
  wb_if.master        s,
  output logic [15:0] timeout_count
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
  ,
  output logic [WB_ADDR_WIDTH-1:0] err_addr,
  output logic                     err_valid,
  input  logic                     err_clr
`endif
);

  state_t state;

  logic pass;
  logic tmo;
  logic stall;
  logic hit;

  logic [WB_ADDR_WIDTH-1:0] adr;
  logic [WB_DATA_WIDTH-1:0] rdata;

  assign pass = (state == IDLE) || (state == FWD);
  assign tmo  = (state == TMO);

  assign adr   = m.adr;
  assign rdata = pass ? s.dat_r : '0;

  assign s.adr   = adr;
  assign s.dat_w = m.dat_w;
  assign s.sel   = m.sel;
  assign s.we    = m.we;
  assign s.cti   = m.cti;
  assign s.bte   = m.bte;
  assign s.cyc   = pass & m.cyc;
  assign s.stb   = pass & m.stb;

  assign m.dat_r = rdata;
  assign m.ack   = pass & s.ack;
  assign m.err   = tmo | (pass & s.err);

  // A response in the threshold cycle is not a stall, so it beats the timeout.
  assign stall = (state == FWD) & m.cyc & m.stb
               & ~s.ack & ~s.err;

  wb_stall_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_stall (
    .clk (clk),
    .rstn(rstn),
    .inc (stall),
    .hit (hit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE:    if (m.cyc && m.stb) state <= FWD;
        FWD: begin
          if (!m.cyc)   state <= IDLE;
          else if (hit) state <= TMO;
        end
        TMO:     state <= DRAIN;
        DRAIN:   if (!m.cyc) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      timeout_count <= '0;
    end else if (hit && (timeout_count != 16'hFFFF)) begin
      timeout_count <= timeout_count + 1'b1;
    end
  end

`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
  // A new timeout outranks a clear landing in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_addr  <= '0;
      err_valid <= 1'b0;
    end else if (hit) begin
      err_addr  <= adr;
      err_valid <= 1'b1;
    end else if (err_clr) begin
      err_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Directed bench for wb_timeout_bridge with a cycle-level reference model.
// Capture checks are active when WB_TIMEOUT_BRIDGE_CAPTURE_EN is defined.
module tb_wb_timeout_bridge;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        clr_in;
  logic [15:0] timeout_count;
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
  logic [31:0] err_addr;
  logic        err_valid;
`endif

  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mi ();
  wb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) si ();

  wb_timeout_bridge #(
    .WB_ADDR_WIDTH (32),
    .WB_DATA_WIDTH (32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m            (mi),
    .s            (si),
    .timeout_count(timeout_count)
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
    ,
    .err_addr     (err_addr),
    .err_valid    (err_valid),
    .err_clr      (clr_in)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bus cycle is "open" after its first beat; every
  // later stalled beat counts, and the T-th one schedules the error beat.
  bit          open, killed, fire_now, fire;
  int          waited, n_tmo;
  bit          ev;
  logic [31:0] ea;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      open = 0; killed = 0; fire_now = 0; fire = 0;
      waited = 0; n_tmo = 0; ev = 0; ea = '0;
    end else begin
      fire = 0;
      if (fire_now) begin
        fire_now = 0;
        killed = 1;
      end else if (killed) begin
        if (!mi.cyc) killed = 0;
      end else if (!open) begin
        if (mi.cyc && mi.stb) open = 1;
        waited = 0;
      end else if (!mi.cyc) begin
        open = 0;
        waited = 0;
      end else if (mi.stb && !si.ack && !si.err) begin
        waited++;
        if (waited == T) fire = 1;
      end else begin
        waited = 0;
      end
      if (fire) begin
        fire_now = 1;
        open = 0;
        waited = 0;
        if (n_tmo < 65535) n_tmo++;
        ev = 1;
        ea = mi.adr;
      end else if (clr_in) begin
        ev = 0;
      end
    end
  end

  always @(negedge clk) begin
    bit ok;
    ok = !fire_now && !killed;
    chk("s_cyc", 64'(si.cyc), 64'(ok & mi.cyc));
    chk("s_stb", 64'(si.stb), 64'(ok & mi.stb));
    chk("s_adr", 64'(si.adr), 64'(mi.adr));
    chk("m_ack", 64'(mi.ack), 64'(ok & si.ack));
    chk("m_err", 64'(mi.err), 64'(fire_now | (ok & si.err)));
    chk("m_dat", 64'(mi.dat_r), ok ? 64'(si.dat_r) : 64'd0);
    chk("tcnt", 64'(timeout_count), 64'(n_tmo));
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
    chk("err_valid", 64'(err_valid), 64'(ev));
    chk("err_addr", 64'(err_addr), 64'(ea));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(logic [31:0] a, logic [2:0] c);
    mi.cyc = 1'b1;
    mi.stb = 1'b1;
    mi.adr = a;
    mi.cti = c;
  endtask

  task automatic drop();
    mi.cyc = 1'b0;
    mi.stb = 1'b0;
    si.ack = 1'b0;
    si.err = 1'b0;
  endtask

  int got;
  int acks;

  initial begin
    rstn = 1'b1; clr_in = 1'b0;
    mi.adr = '0; mi.dat_w = 32'h1234_5678; mi.sel = 4'hF;
    mi.we = 1'b0; mi.cti = 3'b000; mi.bte = 2'b00;
    si.dat_r = 32'h0; drop();
    #1 rstn = 1'b0;
    #2;
    chk("rst_tcnt", 64'(timeout_count), 64'd0);
    chk("rst_err", 64'(mi.err), 64'd0);
    mi.cyc = 1'b1; mi.stb = 1'b1;
    #1 chk("rst_pass", 64'(si.cyc), 64'd1);
    drop();
    repeat (2) step();
    rstn = 1'b1;
    step();

    // single read, slave answers after three stalled cycles
    req(32'h0000_1000, wb_sys_pkg::CTI_CLASSIC);
    repeat (3) step();
    si.ack = 1'b1; si.dat_r = 32'hCAFE_F00D;
    #1;
    chk("rd_ack", 64'(mi.ack), 64'd1);
    chk("rd_dat", 64'(mi.dat_r), 64'hCAFE_F00D);
    chk("rd_err", 64'(mi.err), 64'd0);
    step(); drop();
    chk("rd_tcnt", 64'(timeout_count), 64'd0);
    step();

    // slave never answers: error beat lands on cycle 17 (1 + T stalls)
    req(32'h0000_A5A0, wb_sys_pkg::CTI_CLASSIC);
    got = -1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (mi.err) begin got = i; break; end
      step();
    end
    chk("tmo_cycle", 64'(got), 64'd17);
    chk("tmo_scyc", 64'(si.cyc), 64'd0);
    chk("tmo_dat", 64'(mi.dat_r), 64'd0);
    step(); #1;
    chk("tmo_1cyc", 64'(mi.err), 64'd0);
    chk("tmo_tcnt", 64'(timeout_count), 64'd1);
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
    chk("tmo_eaddr", 64'(err_addr), 64'h0000_A5A0);
    chk("tmo_evalid", 64'(err_valid), 64'd1);
`endif
    repeat (2) step();
    drop(); step(); step();

    // ACK on the threshold stall wins over the timeout
    req(32'h0000_2000, wb_sys_pkg::CTI_CLASSIC);
    repeat (16) step();
    si.ack = 1'b1;
    #1;
    chk("thr_ack", 64'(mi.ack), 64'd1);
    chk("thr_err", 64'(mi.err), 64'd0);
    step(); drop(); #1;
    chk("thr_err2", 64'(mi.err), 64'd0);
    chk("thr_tcnt", 64'(timeout_count), 64'd1);
    step();

    // 4-beat burst, 10 stalls per beat
    acks = 0;
    req(32'h0000_3000, wb_sys_pkg::CTI_INCR);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) mi.cti = wb_sys_pkg::CTI_EOB;
      repeat (10) step();
      si.ack = 1'b1;
      #1;
      if (mi.ack) acks++;
      step();
      si.ack = 1'b0;
      mi.adr = mi.adr + 32'd4;
    end
    drop();
    chk("bst_acks", 64'(acks), 64'd4);
    chk("bst_tcnt", 64'(timeout_count), 64'd1);
    step();

    // late ACKs during drain are swallowed
    req(32'h0000_4000, wb_sys_pkg::CTI_CLASSIC);
    repeat (17) step();
    #1 chk("drn_err", 64'(mi.err), 64'd1);
    step();
    for (int i = 0; i < 5; i++) begin
      si.ack = 1'b1;
      #1;
      chk("drn_ack", 64'(mi.ack), 64'd0);
      chk("drn_scyc", 64'(si.cyc), 64'd0);
      step();
    end
    drop(); step();
    req(32'h0000_4100, wb_sys_pkg::CTI_CLASSIC);
    #1 chk("drn_idle", 64'(si.cyc), 64'd1);
    chk("drn_tcnt", 64'(timeout_count), 64'd2);
    step(); drop(); step();

    // clear, then timeout coinciding with another clear
    clr_in = 1'b1; step(); clr_in = 1'b0;
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
    #1 chk("clr_evalid", 64'(err_valid), 64'd0);
`endif
    req(32'h0000_5000, wb_sys_pkg::CTI_CLASSIC);
    repeat (16) step();
    clr_in = 1'b1;
    step();
    clr_in = 1'b0;
    #1;
    chk("sc_err", 64'(mi.err), 64'd1);
    chk("sc_tcnt", 64'(timeout_count), 64'd3);
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
    chk("sc_evalid", 64'(err_valid), 64'd1);
    chk("sc_eaddr", 64'(err_addr), 64'h0000_5000);
`endif
    step(); drop(); step(); step();

    // reset pulsed in the middle of a stall
    req(32'h0000_6000, wb_sys_pkg::CTI_CLASSIC);
    repeat (5) step();
    #2 rstn = 1'b0;
    #1;
    chk("mrst_err", 64'(mi.err), 64'd0);
    chk("mrst_tcnt", 64'(timeout_count), 64'd0);
    chk("mrst_pass", 64'(si.cyc), 64'd1);
`ifdef WB_TIMEOUT_BRIDGE_CAPTURE_EN
    chk("mrst_evalid", 64'(err_valid), 64'd0);
`endif
    step();
    drop();
    rstn = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wb_timeout_bridge.md
WB_TIMEOUT_BRIDGE -- requirements
Module: wb_timeout_bridge

Interface
REQ-001 The block SHALL have parameter WB_ADDR_WIDTH, default 32, Wishbone address width.
REQ-002 The block SHALL have parameter WB_DATA_WIDTH, default 32, Wishbone data width (multiple of 8).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 256, stall cycles before forced error; legal range 2..65535.
REQ-004 The block SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-005 The block SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-006 The block SHALL have port m, wb_if.slave, WB_ADDR/WB_DATA widths, upstream side, connected to one interconnect slave port (sN).
REQ-007 The block SHALL have port s, wb_if.master, WB_ADDR/WB_DATA widths, downstream side, connected to the target slave.
REQ-008 The block SHALL have port timeout_count, output, 16, saturating count of timeouts since reset.
REQ-009 With WB_TIMEOUT_BRIDGE_CAPTURE_EN only, the block SHALL have these ports: err_addr, output, WB_ADDR_WIDTH, captured address; err_valid, output, 1, sticky flag; err_clr, input, 1, clears err_valid.

Function
REQ-010 The FSM SHALL have states IDLE, FWD, TMO and DRAIN.
REQ-011 In IDLE and FWD, ADR, DAT_W, SEL, WE, CTI, BTE, CYC and STB SHALL pass m->s combinationally (zero latency).
REQ-012 In IDLE and FWD, DAT_R, ACK and ERR SHALL pass s->m combinationally.
REQ-013 IDLE SHALL go to FWD when m.CYC=1 and m.STB=1.
REQ-014 FWD SHALL go to IDLE when m.CYC=0.
REQ-015 The stall counter (16 b) SHALL increment each FWD cycle with m.STB=1, s.ACK=0 and s.ERR=0.
REQ-016 The stall counter SHALL clear on s.ACK, on s.ERR, on m.STB=0, and on entry to IDLE.
REQ-017 When the stall counter equals TIMEOUT_CYCLES-1 in a stall cycle, the next state SHALL be TMO; a timeout therefore fires on stall cycle TIMEOUT_CYCLES.
REQ-018 An s.ACK or s.ERR in the same cycle as the threshold SHALL win: it is forwarded, and no timeout occurs.
REQ-019 TMO SHALL last exactly 1 cycle, with m.ERR=1, m.ACK=0, m.DAT_R=0, s.CYC=0 and s.STB=0, then go to DRAIN.
REQ-020 DRAIN SHALL keep s.CYC=0, s.STB=0 and m.ACK=m.ERR=0, ignore late s.ACK/s.ERR, and go to IDLE when m.CYC=0.
REQ-021 A burst (CTI=010) SHALL restart the stall counter at each beat ACK; a timeout SHALL abort the whole burst.
REQ-022 timeout_count SHALL increment on entry to TMO and saturate at 16'hFFFF.

Reset
REQ-023 rstn=0 SHALL force state=IDLE, stall counter=0, timeout_count=0, err_valid=0 and err_addr=0 asynchronously; release is synchronous to clk.
REQ-024 Combinational outputs SHALL follow IDLE pass-through during reset.
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer with no ERR generated.

Configuration
REQ-026 With WB_TIMEOUT_BRIDGE_CAPTURE_EN defined, entry to TMO SHALL latch m.ADR into err_addr and set err_valid; err_valid SHALL clear when err_clr=1; a set and a clear in the same cycle SHALL leave err_valid=1; err_addr SHALL hold until the next timeout.
REQ-027 With WB_TIMEOUT_BRIDGE_CAPTURE_EN undefined, err_addr, err_valid and err_clr SHALL be absent and the capture logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 The shared package wb_sys_pkg SHALL hold the FSM state typedef (IDLE/FWD/TMO/DRAIN) and the CTI encodings (classic 000, incrementing 010, end-of-burst 111).
REQ-029 A sub-module wb_stall_counter SHALL hold the clear/increment/threshold counter; the FSM and pass-through muxing SHALL stay in the top.

Verification
REQ-030 Single read, slave ACKs on stall cycle 3 -> m.ACK on the same cycle, DAT_R=s.DAT_R, timeout_count=0.
REQ-031 TIMEOUT_CYCLES=16, slave never ACKs -> m.ERR for 1 cycle after 16 stall cycles, s.CYC=0 from that cycle, timeout_count=1, err_addr=m.ADR (capture build).
REQ-032 TIMEOUT_CYCLES=16, s.ACK on the 16th stall cycle -> ACK forwarded, no ERR, timeout_count unchanged.
REQ-033 4-beat burst, 10 stall cycles per beat, TIMEOUT_CYCLES=16 -> all 4 ACKs forwarded, no timeout.
REQ-034 Late s.ACK in DRAIN, master holds CYC for 5 cycles -> no m.ACK, s.CYC=0, then IDLE after CYC drops.
REQ-035 rstn pulsed low mid-stall, plus err_clr and a timeout in the same cycle (capture build) -> outputs reset immediately with no ERR; err_valid stays 1.
